// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the load/store unit (master) and
// the single-port data memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_ren;
  logic              dmem_wen;
  logic [3:0]        dmem_mask;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_addr, dmem_ren, dmem_wen, dmem_mask, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_addr, dmem_ren, dmem_wen, dmem_mask, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: checks alignment, issues one data-memory
// access at a time, stalls the pipeline while it is outstanding, and returns
// lane-extracted, sign/zero-extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_byte_off,
  input  logic [1:0]        i_size,
  input  logic [3:0]        i_mask,
  input  logic              i_unsigned,
  input  logic [31:0]       i_wdata,
  mem_access_unit_if.master dmem,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_load_data,
  output logic              o_misaligned,
  output logic              o_err
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [1:0]        size_q, off_q;
  logic              uns_q, load_q;
  logic [31:0]       wdata_q, wdata_rep;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic              done_q, done_d, mis_q, mis_d, err_q, err_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              start, legal, accept;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ext;

  assign start = i_valid & (i_MemRead | i_MemWrite);

  // Alignment/size legality of the incoming access.
  always_comb begin
    legal = 1'b0;
    unique case (i_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~i_byte_off[0];
      2'b10:   legal = (i_byte_off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) & start & legal;

  // Replicate store data across lanes; the mask picks which lanes land.
  always_comb begin
    wdata_rep = i_wdata;
    unique case (i_size)
      2'b00:   wdata_rep = {4{i_wdata[7:0]}};
      2'b01:   wdata_rep = {2{i_wdata[15:0]}};
      default: wdata_rep = i_wdata;
    endcase
  end

  // Extract and extend the addressed lane of the read word.
  always_comb begin
    lane_b = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    ext    = dmem.dmem_rdata;
    unique case (size_q)
      2'b00:   ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: ext = dmem.dmem_rdata;
    endcase
  end

  // Next state, completion/abort pulses and pipeline stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    err_d       = 1'b0;
    load_data_d = load_data_q;
    o_stall     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (legal) begin
            state_d = StReq;
            cnt_d   = '0;
            o_stall = 1'b1;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      StReq: begin
        o_stall = 1'b1;
        // Stall drops on the accepting edge so upstream advances exactly once.
        if (dmem.dmem_ready && !load_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
          o_stall = 1'b0;
        end else if (dmem.dmem_ready && dmem.dmem_rvalid) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          load_data_d = ext;
          o_stall     = 1'b0;
        end else if (dmem.dmem_ready) begin
          state_d = StResp;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q >= CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        o_stall = ~dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          load_data_d = ext;
        end else if (cnt_q >= CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request strobes are registered and only ever high while in REQ.
  always_comb begin
    ren_d = (state_d == StReq) & (accept ? ~i_MemWrite : load_q);
    wen_d = (state_d == StReq) & (accept ? i_MemWrite : ~load_q);
  end

  // State, latched access fields and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      if (accept) begin
        addr_q  <= i_addr;
        mask_q  <= i_mask;
        size_q  <= i_size;
        off_q   <= i_byte_off;
        uns_q   <= i_unsigned;
        load_q  <= ~i_MemWrite;  // read+write together counts as a store
        wdata_q <= wdata_rep;
      end
    end
  end

  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_ren   = ren_q;
  assign dmem.dmem_wen   = wen_q;
  assign dmem.dmem_mask  = mask_q;
  assign dmem.dmem_wdata = wdata_q;
  assign o_done          = done_q;
  assign o_load_data     = load_data_q;
  assign o_misaligned    = mis_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scenario tasks plus a scoreboard
// of expected load results consumed on every o_done pulse.
module tb_mem_access_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  off = '0, size = '0;
  logic [3:0]  mask = '0;
  logic        uns = 1'b0;
  logic [31:0] wdata = '0;
  logic        stall, done, misaligned, err;
  logic [31:0] load_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) dmem ();

  mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_MemRead    (mem_read),
    .i_MemWrite   (mem_write),
    .i_addr       (addr),
    .i_byte_off   (off),
    .i_size       (size),
    .i_mask       (mask),
    .i_unsigned   (uns),
    .i_wdata      (wdata),
    .dmem         (dmem),
    .o_stall      (stall),
    .o_done       (done),
    .o_load_data  (load_data),
    .o_misaligned (misaligned),
    .o_err        (err)
  );

  // Scoreboard: every completion pops one expected load_data value.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: load_data=%h, nothing expected", load_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (load_data !== exp_w) begin
          errors++;
          $display("FAIL sb_load_data: got %h want %h", load_data, exp_w);
        end
      end
    end
    if (rst_n && (done | misaligned | err)) begin
      checks++;
      if ($countones({done, misaligned, err}) != 1) begin
        errors++;
        $display("FAIL pulse_exclusive: done/mis/err=%b want one-hot",
                 {done, misaligned, err});
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] o, input logic [1:0] s,
                       input logic [3:0] m, input logic u, input logic [31:0] wd);
    valid = 1'b1; mem_read = rd; mem_write = wr; addr = a;
    off = o; size = s; mask = m; uns = u; wdata = wd;
  endtask

  task automatic drop();
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    checks++;
    if ({dmem.dmem_ren, dmem.dmem_wen, done, misaligned, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ren/wen/done/mis/err=%b want 00000",
               {dmem.dmem_ren, dmem.dmem_wen, done, misaligned, err});
    end
    checks++;
    if (load_data !== 32'h0) begin
      errors++; $display("FAIL reset_load_data: got %h want 0", load_data);
    end
    checks++;
    if ({dmem.dmem_addr, dmem.dmem_mask, dmem.dmem_wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h mask=%b wdata=%h want 0",
                         dmem.dmem_addr, dmem.dmem_mask, dmem.dmem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_half_same_cycle();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h104, 2'd2, 2'b01, 4'b1100, 1'b1, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL half_stall_start: got %b want 1", stall);
    end
    @(negedge clk);
    checks++;
    if ({dmem.dmem_ren, dmem.dmem_wen, dmem.dmem_mask} !== 6'b10_1100 ||
        dmem.dmem_addr !== 32'h104) begin
      errors++; $display("FAIL half_req: ren/wen/mask=%b addr=%h want 101100 104",
                         {dmem.dmem_ren, dmem.dmem_wen, dmem.dmem_mask}, dmem.dmem_addr);
    end
    dmem.dmem_ready = 1'b1; dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hBEEF_0001;
    exp_q.push_back(32'h0000_BEEF);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL half_stall_complete: got %b want 0", stall);
    end
    @(negedge clk);
    dmem.dmem_ready = 1'b0; dmem.dmem_rvalid = 1'b0;
    drop();
    checks++;
    if (done !== 1'b1 || dmem.dmem_ren !== 1'b0) begin
      errors++; $display("FAIL half_done_direct: done=%b ren=%b want 1 0", done, dmem.dmem_ren);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL half_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_byte_store();
    int wen_cycles = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h200, 2'd1, 2'b00, 4'b0010, 1'b0, 32'h1234_56AB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dmem.dmem_wen === 1'b1 && dmem.dmem_ren === 1'b0) wen_cycles++;
      if (i == 0) begin
        checks++;
        if (dmem.dmem_wdata !== 32'hABAB_ABAB || dmem.dmem_mask !== 4'b0010) begin
          errors++; $display("FAIL store_bus: wdata=%h mask=%b want abababab 0010",
                             dmem.dmem_wdata, dmem.dmem_mask);
        end
      end
      if (i == 3) begin
        dmem.dmem_ready = 1'b1;
        exp_q.push_back(32'h0000_BEEF);  // a store leaves load_data alone
      end
    end
    @(negedge clk);
    dmem.dmem_ready = 1'b0;
    drop();
    checks++;
    if (wen_cycles != 4) begin
      errors++; $display("FAIL store_wen_cycles: got %0d want 4", wen_cycles);
    end
    checks++;
    if (done !== 1'b1 || dmem.dmem_wen !== 1'b0) begin
      errors++; $display("FAIL store_done: done=%b wen=%b want 1 0", done, dmem.dmem_wen);
    end
  endtask

  task automatic test_signed_byte_load();
    int stalls = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h100, 2'd3, 2'b00, 4'b1000, 1'b0, 32'h0);
    #1 stalls += int'(stall);
    @(negedge clk);
    checks++;
    if (dmem.dmem_ren !== 1'b1 || dmem.dmem_addr !== 32'h100 || dmem.dmem_mask !== 4'b1000) begin
      errors++; $display("FAIL sbyte_req: ren=%b addr=%h mask=%b want 1 100 1000",
                         dmem.dmem_ren, dmem.dmem_addr, dmem.dmem_mask);
    end
    dmem.dmem_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FF80);
    #1 stalls += int'(stall);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem.dmem_ready = 1'b0;
      if (i == 0) begin
        checks++;
        if (dmem.dmem_ren !== 1'b0) begin
          errors++; $display("FAIL sbyte_ren_drop: got %b want 0", dmem.dmem_ren);
        end
      end
      if (i == 2) begin
        dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'h80FF_1234;
      end
      #1 stalls += int'(stall);
    end
    @(negedge clk);
    dmem.dmem_rvalid = 1'b0;
    drop();
    checks++;
    if (stalls != 4) begin
      errors++; $display("FAIL sbyte_stall_cycles: got %0d want 4", stalls);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL sbyte_done: got %b want 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || load_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL sbyte_hold: done=%b data=%h want 0 ffffff80", done, load_data);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h300, 2'd0, 2'b10, 4'b1111, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drop();
      checks++;
      if (dmem.dmem_ren !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: ren=%b err=%b want 1 0",
                           i, dmem.dmem_ren, err);
      end
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || dmem.dmem_ren !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: err=%b ren=%b done=%b want 1 0 0",
                         err, dmem.dmem_ren, done);
    end
    checks++;
    if (load_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL timeout_keep_data: got %h want ffffff80", load_data);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL timeout_err_pulse: got %b want 0", err);
    end
  endtask

  task automatic test_misaligned();
    logic [5:0] tbl [3];  // {rd, wr, off, size}
    tbl[0] = {1'b1, 1'b0, 2'd1, 2'b01};
    tbl[1] = {1'b0, 1'b1, 2'd2, 2'b10};
    tbl[2] = {1'b1, 1'b0, 2'd0, 2'b11};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(tbl[k][5], tbl[k][4], 32'h500, tbl[k][3:2], tbl[k][1:0], 4'b1111, 1'b0,
            32'hCAFE_F00D);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL mis%0d_stall: got %b want 0", k, stall);
      end
      @(negedge clk);
      drop();
      checks++;
      if ({misaligned, dmem.dmem_ren, dmem.dmem_wen, done} !== 4'b1000) begin
        errors++; $display("FAIL mis%0d_pulse: mis/ren/wen/done=%b want 1000",
                           k, {misaligned, dmem.dmem_ren, dmem.dmem_wen, done});
      end
      @(negedge clk);
      checks++;
      if ({misaligned, dmem.dmem_ren, dmem.dmem_wen} !== 3'b000) begin
        errors++; $display("FAIL mis%0d_after: mis/ren/wen=%b want 000",
                           k, {misaligned, dmem.dmem_ren, dmem.dmem_wen});
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h400, 2'd0, 2'b10, 4'b1111, 1'b0, 32'h0);
    @(negedge clk);
    dmem.dmem_ready = 1'b1;
    @(negedge clk);
    dmem.dmem_ready = 1'b0;
    drop();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, dmem.dmem_ren, dmem.dmem_wen, done, misaligned, err} !== 6'b0 ||
        load_data !== 32'h0 || dmem.dmem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs: flags=%b data=%h addr=%h want 0",
                         {stall, dmem.dmem_ren, dmem.dmem_wen, done, misaligned, err},
                         load_data, dmem.dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem.dmem_rvalid = 1'b0;
    checks++;
    if (done !== 1'b0 || load_data !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_late_rvalid: done=%b data=%h stall=%b want 0 0 0",
                         done, load_data, stall);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_done: got %b want 0", done);
    end
  endtask

  initial begin
    dmem.dmem_ready  = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    dmem.dmem_rdata  = '0;
    test_reset();
    test_half_same_cycle();
    test_byte_store();
    test_signed_byte_load();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected completions missing", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
